pic_command_sequencer: RTL and testbench

Sequential command-register stage directly downstream of the PIC bus-control decoder. Converts the decoder's level write strobes and latched internal data byte into single write events. Steps the ICW1→ICW2→(ICW3)→(ICW4) initialization sequence, then holds every configuration, mask and mode bit that the priority resolver, interrupt-request and cascade logic consume. OCW2/OCW3 command bytes are decoded into one-cycle command pulses and persistent mode flags.

---
 rtl/pic_pkg.sv | 56 +++++
 rtl/pic_command_sequencer_write_event_detect.sv | 27 ++
 rtl/pic_command_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_pic_command_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC command sequencer.
// Optional feature macro: PIC_SPECIAL_MASK_EN (see pic_command_sequencer.sv).
package pic_pkg;

  // Initialization / run state of the command sequencer
  typedef enum logic [2:0] {
    StUninit,
    StWaitIcw2,
    StWaitIcw3,
    StWaitIcw4,
    StReady
  } seq_state_e;

  // Strobe / event vector positions
  localparam int unsigned EvIcw1   = 0;
  localparam int unsigned EvIcw24  = 1;
  localparam int unsigned EvOcw1   = 2;
  localparam int unsigned EvOcw2   = 3;
  localparam int unsigned EvOcw3   = 4;
  localparam int unsigned NumEvent = 5;

  // OCW2 command field {R, SL, EOI} = bus[7:5]
  localparam logic [2:0] Ocw2RotAeoiClr    = 3'b000;
  localparam logic [2:0] Ocw2EoiNonSpec    = 3'b001;
  localparam logic [2:0] Ocw2Nop           = 3'b010;
  localparam logic [2:0] Ocw2EoiSpec       = 3'b011;
  localparam logic [2:0] Ocw2RotAeoiSet    = 3'b100;
  localparam logic [2:0] Ocw2RotEoiNonSpec = 3'b101;
  localparam logic [2:0] Ocw2SetPrio       = 3'b110;
  localparam logic [2:0] Ocw2RotEoiSpec    = 3'b111;

  // Bit positions inside the 3-bit OCW2 command field
  localparam int unsigned Ocw2CmdEoiBit = 0;
  localparam int unsigned Ocw2CmdSlBit  = 1;
  localparam int unsigned Ocw2CmdRBit   = 2;

  // ICW1 bit positions
  localparam int unsigned Icw1Ic4Bit  = 0;
  localparam int unsigned Icw1SnglBit = 1;
  localparam int unsigned Icw1LtimBit = 3;

  // ICW4 bit positions
  localparam int unsigned Icw4UpmBit  = 0;
  localparam int unsigned Icw4AeoiBit = 1;
  localparam int unsigned Icw4MsBit   = 2;
  localparam int unsigned Icw4BufBit  = 3;
  localparam int unsigned Icw4SfnmBit = 4;

  // OCW3 bit positions
  localparam int unsigned Ocw3RisBit  = 0;
  localparam int unsigned Ocw3RrBit   = 1;
  localparam int unsigned Ocw3PBit    = 2;
  localparam int unsigned Ocw3SmmBit  = 5;
  localparam int unsigned Ocw3EsmmBit = 6;

endpackage

// File: rtl/pic_command_sequencer_write_event_detect.sv
// Turns level write strobes into single-cycle rising-edge events.
module write_event_detect #(
  parameter int unsigned Width = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [Width-1:0] strobe,
  output logic [Width-1:0] event_pulse
);

  logic [Width-1:0] strobe_q;

  // Remember last-cycle strobe levels
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q <= '0;
    end else begin
      strobe_q <= strobe;
    end
  end

  // Event is the first cycle a strobe is seen high
  always_comb begin
    event_pulse = strobe & ~strobe_q;
  end

endmodule

// File: rtl/pic_command_sequencer.sv
// PIC command-register stage: ICW init sequencing, IMR, OCW2/OCW3 decode.
// Optional feature macro: PIC_SPECIAL_MASK_EN enables OCW3 special mask mode;
// when undefined special_mask is tied low.
module pic_command_sequencer
  import pic_pkg::*;
#(
  parameter logic [7:0] IMR_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       write_ICW_1,
  input  logic       write_ICW2_4,
  input  logic       write_OCW1,
  input  logic       write_OCW2,
  input  logic       write_OCW3,
  input  logic [7:0] internal_bus,
  output logic       init_done,
  output logic       ltim,
  output logic       single_mode,
  output logic [4:0] vector_base,
  output logic [7:0] cascade_cfg,
  output logic       upm_8086,
  output logic       auto_eoi,
  output logic       master_slave,
  output logic       buffered_mode,
  output logic       sfnm,
  output logic [7:0] imr,
  output logic       eoi_pulse,
  output logic       eoi_specific,
  output logic       eoi_rotate,
  output logic [2:0] cmd_level,
  output logic       set_prio_pulse,
  output logic       rotate_in_aeoi,
  output logic       read_isr,
  output logic       poll_pulse,
  output logic       special_mask
);

  seq_state_e          state_q;
  logic                ic4_q;
  logic [NumEvent-1:0] evt;
  logic                ev_icw1;
  logic                ev_mid;
  logic                ev_icw24;
  logic                ev_ocw1;
  logic                ev_ocw2;
  logic                ev_ocw3;
  logic [2:0]          ocw2_cmd;

  write_event_detect #(
    .Width(NumEvent)
  ) u_write_event_detect (
    .clk        (clk),
    .reset_n    (reset_n),
    .strobe     ({write_OCW3, write_OCW2, write_OCW1, write_ICW2_4, write_ICW_1}),
    .event_pulse(evt)
  );

  // Resolve coincident events: ICW1 > ICW2_4/OCW1 > OCW2 > OCW3
  always_comb begin
    ev_icw1  = evt[EvIcw1];
    ev_mid   = ~ev_icw1 & (evt[EvIcw24] | evt[EvOcw1]);
    ev_icw24 = ~ev_icw1 & evt[EvIcw24];
    ev_ocw1  = ~ev_icw1 & evt[EvOcw1];
    ev_ocw2  = ~ev_icw1 & ~ev_mid & evt[EvOcw2] & (state_q == StReady);
    ev_ocw3  = ~ev_icw1 & ~ev_mid & ~evt[EvOcw2] & evt[EvOcw3] & (state_q == StReady);
    ocw2_cmd = internal_bus[7:5];
  end

  // Init sequence FSM with all registered configuration and command outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StUninit;
      ic4_q          <= 1'b0;
      init_done      <= 1'b0;
      ltim           <= 1'b0;
      single_mode    <= 1'b0;
      vector_base    <= '0;
      cascade_cfg    <= '0;
      upm_8086       <= 1'b0;
      auto_eoi       <= 1'b0;
      master_slave   <= 1'b0;
      buffered_mode  <= 1'b0;
      sfnm           <= 1'b0;
      imr            <= '0;
      eoi_pulse      <= 1'b0;
      eoi_specific   <= 1'b0;
      eoi_rotate     <= 1'b0;
      cmd_level      <= '0;
      set_prio_pulse <= 1'b0;
      rotate_in_aeoi <= 1'b0;
      read_isr       <= 1'b0;
      poll_pulse     <= 1'b0;
    end else begin
      eoi_pulse      <= 1'b0;
      set_prio_pulse <= 1'b0;
      poll_pulse     <= 1'b0;
      if (ev_icw1) begin
        // ICW1 restarts initialization from any state
        state_q        <= StWaitIcw2;
        init_done      <= 1'b0;
        ltim           <= internal_bus[Icw1LtimBit];
        single_mode    <= internal_bus[Icw1SnglBit];
        ic4_q          <= internal_bus[Icw1Ic4Bit];
        imr            <= IMR_INIT;
        rotate_in_aeoi <= 1'b0;
        read_isr       <= 1'b0;
        upm_8086       <= 1'b0;
        auto_eoi       <= 1'b0;
        master_slave   <= 1'b0;
        buffered_mode  <= 1'b0;
        sfnm           <= 1'b0;
      end else begin
        case (state_q)
          StWaitIcw2: begin
            if (ev_icw24) begin
              vector_base <= internal_bus[7:3];
              if (!single_mode) begin
                state_q <= StWaitIcw3;
              end else if (ic4_q) begin
                state_q <= StWaitIcw4;
              end else begin
                state_q   <= StReady;
                init_done <= 1'b1;
              end
            end
          end
          StWaitIcw3: begin
            if (ev_icw24) begin
              cascade_cfg <= internal_bus;
              if (ic4_q) begin
                state_q <= StWaitIcw4;
              end else begin
                state_q   <= StReady;
                init_done <= 1'b1;
              end
            end
          end
          StWaitIcw4: begin
            if (ev_icw24) begin
              upm_8086      <= internal_bus[Icw4UpmBit];
              auto_eoi      <= internal_bus[Icw4AeoiBit];
              master_slave  <= internal_bus[Icw4MsBit];
              buffered_mode <= internal_bus[Icw4BufBit];
              sfnm          <= internal_bus[Icw4SfnmBit];
              state_q       <= StReady;
              init_done     <= 1'b1;
            end
          end
          StReady: begin
            // A1=1 writes in READY are OCW1; the ICW2_4 alias is ignored
            if (ev_ocw1) begin
              imr <= internal_bus;
            end
          end
          default: ;
        endcase

        if (ev_ocw2) begin
          cmd_level    <= internal_bus[2:0];
          eoi_specific <= ocw2_cmd[Ocw2CmdEoiBit] & ocw2_cmd[Ocw2CmdSlBit];
          eoi_rotate   <= ocw2_cmd[Ocw2CmdEoiBit] & ocw2_cmd[Ocw2CmdRBit];
          case (ocw2_cmd)
            Ocw2EoiNonSpec, Ocw2EoiSpec,
            Ocw2RotEoiNonSpec, Ocw2RotEoiSpec: eoi_pulse      <= 1'b1;
            Ocw2RotAeoiSet:                    rotate_in_aeoi <= 1'b1;
            Ocw2RotAeoiClr:                    rotate_in_aeoi <= 1'b0;
            Ocw2SetPrio:                       set_prio_pulse <= 1'b1;
            default: ;  // Ocw2Nop
          endcase
        end

        if (ev_ocw3) begin
          if (internal_bus[Ocw3RrBit]) begin
            read_isr <= internal_bus[Ocw3RisBit];
          end
          if (internal_bus[Ocw3PBit]) begin
            poll_pulse <= 1'b1;
          end
        end
      end
    end
  end

`ifdef PIC_SPECIAL_MASK_EN
  // Special mask mode: set/cleared by OCW3 ESMM/SMM, cleared by ICW1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      special_mask <= 1'b0;
    end else if (ev_icw1) begin
      special_mask <= 1'b0;
    end else if (ev_ocw3 && internal_bus[Ocw3EsmmBit]) begin
      special_mask <= internal_bus[Ocw3SmmBit];
    end
  end
`else
  assign special_mask = 1'b0;
`endif

endmodule

// File: tb/tb_pic_command_sequencer.sv
// Self-checking bench for pic_command_sequencer: vector table + scoreboard.
module tb_pic_command_sequencer;

`ifdef PIC_SPECIAL_MASK_EN
  localparam int SmmEn = 1;
`else
  localparam int SmmEn = 0;
`endif

  localparam logic [4:0] StbIcw1  = 5'b00001;
  localparam logic [4:0] StbIcw24 = 5'b00010;
  localparam logic [4:0] StbOcw1  = 5'b00100;
  localparam logic [4:0] StbOcw2  = 5'b01000;
  localparam logic [4:0] StbOcw3  = 5'b10000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       write_ICW_1, write_ICW2_4, write_OCW1, write_OCW2, write_OCW3;
  logic [7:0] internal_bus;
  logic       init_done, ltim, single_mode;
  logic [4:0] vector_base;
  logic [7:0] cascade_cfg;
  logic       upm_8086, auto_eoi, master_slave, buffered_mode, sfnm;
  logic [7:0] imr;
  logic       eoi_pulse, eoi_specific, eoi_rotate;
  logic [2:0] cmd_level;
  logic       set_prio_pulse, rotate_in_aeoi, read_isr, poll_pulse, special_mask;

  always #5 clk = ~clk;

  pic_command_sequencer #(
    .IMR_INIT(8'h00)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .write_ICW_1   (write_ICW_1),
    .write_ICW2_4  (write_ICW2_4),
    .write_OCW1    (write_OCW1),
    .write_OCW2    (write_OCW2),
    .write_OCW3    (write_OCW3),
    .internal_bus  (internal_bus),
    .init_done     (init_done),
    .ltim          (ltim),
    .single_mode   (single_mode),
    .vector_base   (vector_base),
    .cascade_cfg   (cascade_cfg),
    .upm_8086      (upm_8086),
    .auto_eoi      (auto_eoi),
    .master_slave  (master_slave),
    .buffered_mode (buffered_mode),
    .sfnm          (sfnm),
    .imr           (imr),
    .eoi_pulse     (eoi_pulse),
    .eoi_specific  (eoi_specific),
    .eoi_rotate    (eoi_rotate),
    .cmd_level     (cmd_level),
    .set_prio_pulse(set_prio_pulse),
    .rotate_in_aeoi(rotate_in_aeoi),
    .read_isr      (read_isr),
    .poll_pulse    (poll_pulse),
    .special_mask  (special_mask)
  );

  typedef struct packed {
    logic       init_done;
    logic       ltim;
    logic       single_mode;
    logic [4:0] vector_base;
    logic [7:0] cascade_cfg;
    logic [4:0] icw4;  // {sfnm, buffered, master_slave, auto_eoi, upm_8086}
    logic [7:0] imr;
    logic       eoi_pulse;
    logic       eoi_specific;
    logic       eoi_rotate;
    logic [2:0] cmd_level;
    logic       set_prio_pulse;
    logic       rotate_in_aeoi;
    logic       read_isr;
    logic       poll_pulse;
    logic       special_mask;
  } outs_t;

  typedef struct {
    string      name;
    logic [4:0] strb;
    logic [7:0] data;
    int         hold;
    bit         gap;
    outs_t      exp;
  } vec_t;

  outs_t act;
  always_comb begin
    act = {init_done, ltim, single_mode, vector_base, cascade_cfg,
           sfnm, buffered_mode, master_slave, auto_eoi, upm_8086, imr,
           eoi_pulse, eoi_specific, eoi_rotate, cmd_level,
           set_prio_pulse, rotate_in_aeoi, read_isr, poll_pulse, special_mask};
  end

  outs_t sb_q[$];
  string nm_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  vec_t  vecs[26];

  function automatic outs_t mk(int id, int lt, int sg, int vb, int cc, int i4, int im,
                               int ep, int es, int er, int lv,
                               int sp, int ra, int ri, int pl, int sm);
    outs_t o;
    o.init_done      = 1'(id);
    o.ltim           = 1'(lt);
    o.single_mode    = 1'(sg);
    o.vector_base    = 5'(vb);
    o.cascade_cfg    = 8'(cc);
    o.icw4           = 5'(i4);
    o.imr            = 8'(im);
    o.eoi_pulse      = 1'(ep);
    o.eoi_specific   = 1'(es);
    o.eoi_rotate     = 1'(er);
    o.cmd_level      = 3'(lv);
    o.set_prio_pulse = 1'(sp);
    o.rotate_in_aeoi = 1'(ra);
    o.read_isr       = 1'(ri);
    o.poll_pulse     = 1'(pl);
    o.special_mask   = 1'(sm);
    return o;
  endfunction

  function automatic outs_t no_pulse(outs_t o);
    outs_t r = o;
    r.eoi_pulse      = 1'b0;
    r.set_prio_pulse = 1'b0;
    r.poll_pulse     = 1'b0;
    return r;
  endfunction

  task automatic expect_out(input outs_t e, input string n);
    sb_q.push_back(e);
    nm_q.push_back(n);
  endtask

  task automatic check_one();
    outs_t e;
    string n;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %h required an expected entry", act);
    end else begin
      e = sb_q.pop_front();
      n = nm_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h required %h", n, act, e);
      end
    end
  endtask

  // Entered and left at a falling edge
  task automatic run_vec(input vec_t v);
    {write_OCW3, write_OCW2, write_OCW1, write_ICW2_4, write_ICW_1} = v.strb;
    internal_bus = v.data;
    expect_out(v.exp, v.name);
    @(posedge clk); #1 check_one();
    for (int k = 1; k < v.hold; k++) begin
      @(negedge clk);
      expect_out(no_pulse(v.exp), {v.name, "_hold"});
      @(posedge clk); #1 check_one();
    end
    @(negedge clk);
    {write_OCW3, write_OCW2, write_OCW1, write_ICW2_4, write_ICW_1} = '0;
    if (v.gap) begin
      expect_out(no_pulse(v.exp), {v.name, "_idle"});
      @(posedge clk); #1 check_one();
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required test completion");
    $fatal(1);
  end

  initial begin
    vec_t post;
    reset_n      = 1'b0;
    write_ICW_1  = 1'b0;
    write_ICW2_4 = 1'b0;
    write_OCW1   = 1'b0;
    write_OCW2   = 1'b0;
    write_OCW3   = 1'b0;
    internal_bus = 8'h00;

    //                 id lt sg vb    cc    i4    imr   ep es er lv sp ra ri pl sm
    vecs[0]  = '{"ocw2_preinit", StbOcw2, 8'h63, 1, 1'b1,
                 mk(0, 0, 0, 0,    0,    0,    0,    0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[1]  = '{"icw1_single", StbIcw1, 8'h13, 1, 1'b0,
                 mk(0, 0, 1, 0,    0,    0,    0,    0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[2]  = '{"icw2_single", StbIcw24, 8'h40, 1, 1'b1,
                 mk(0, 0, 1, 'h08, 0,    0,    0,    0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[3]  = '{"icw4_single", StbIcw24, 8'h03, 1, 1'b1,
                 mk(1, 0, 1, 'h08, 0,    'h03, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[4]  = '{"icw1_cascade", StbIcw1, 8'h19, 1, 1'b0,
                 mk(0, 1, 0, 'h08, 0,    0,    0,    0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[5]  = '{"icw2_cascade", StbIcw24, 8'h48, 1, 1'b1,
                 mk(0, 1, 0, 'h09, 0,    0,    0,    0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[6]  = '{"icw3", StbIcw24, 8'h04, 1, 1'b1,
                 mk(0, 1, 0, 'h09, 'h04, 0,    0,    0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[7]  = '{"icw4_cascade", StbIcw24, 8'h01, 2, 1'b0,
                 mk(1, 1, 0, 'h09, 'h04, 'h01, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[8]  = '{"ocw1_hold", StbOcw1, 8'hA5, 4, 1'b0,
                 mk(1, 1, 0, 'h09, 'h04, 'h01, 'hA5, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[9]  = '{"eoi_spec", StbOcw2, 8'h63, 1, 1'b1,
                 mk(1, 1, 0, 'h09, 'h04, 'h01, 'hA5, 1, 1, 0, 3, 0, 0, 0, 0, 0)};
    vecs[10] = '{"eoi_spec_rot", StbOcw2, 8'hE2, 1, 1'b1,
                 mk(1, 1, 0, 'h09, 'h04, 'h01, 'hA5, 1, 1, 1, 2, 0, 0, 0, 0, 0)};
    vecs[11] = '{"eoi_rot", StbOcw2, 8'hA1, 1, 1'b1,
                 mk(1, 1, 0, 'h09, 'h04, 'h01, 'hA5, 1, 0, 1, 1, 0, 0, 0, 0, 0)};
    vecs[12] = '{"eoi_nonspec", StbOcw2, 8'h20, 1, 1'b1,
                 mk(1, 1, 0, 'h09, 'h04, 'h01, 'hA5, 1, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[13] = '{"raeoi_set", StbOcw2, 8'h80, 1, 1'b1,
                 mk(1, 1, 0, 'h09, 'h04, 'h01, 'hA5, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
    vecs[14] = '{"set_prio", StbOcw2, 8'hC5, 1, 1'b1,
                 mk(1, 1, 0, 'h09, 'h04, 'h01, 'hA5, 0, 0, 0, 5, 1, 1, 0, 0, 0)};
    vecs[15] = '{"raeoi_clr", StbOcw2, 8'h00, 1, 1'b1,
                 mk(1, 1, 0, 'h09, 'h04, 'h01, 'hA5, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[16] = '{"ocw2_nop", StbOcw2, 8'h47, 1, 1'b0,
                 mk(1, 1, 0, 'h09, 'h04, 'h01, 'hA5, 0, 0, 0, 7, 0, 0, 0, 0, 0)};
    vecs[17] = '{"ocw3_read_isr", StbOcw3, 8'h0B, 1, 1'b1,
                 mk(1, 1, 0, 'h09, 'h04, 'h01, 'hA5, 0, 0, 0, 7, 0, 0, 1, 0, 0)};
    vecs[18] = '{"ocw3_poll", StbOcw3, 8'h0C, 1, 1'b1,
                 mk(1, 1, 0, 'h09, 'h04, 'h01, 'hA5, 0, 0, 0, 7, 0, 0, 1, 1, 0)};
    vecs[19] = '{"ocw3_smm", StbOcw3, 8'h68, 1, 1'b1,
                 mk(1, 1, 0, 'h09, 'h04, 'h01, 'hA5, 0, 0, 0, 7, 0, 0, 1, 0, SmmEn)};
    vecs[20] = '{"ocw3_read_irr", StbOcw3, 8'h0A, 1, 1'b0,
                 mk(1, 1, 0, 'h09, 'h04, 'h01, 'hA5, 0, 0, 0, 7, 0, 0, 0, 0, SmmEn)};
    vecs[21] = '{"icw1_beats_ocw2", StbIcw1 | StbOcw2, 8'h13, 1, 1'b1,
                 mk(0, 0, 1, 'h09, 'h04, 0,    0,    0, 0, 0, 7, 0, 0, 0, 0, 0)};
    vecs[22] = '{"ocw1_preinit", StbOcw1, 8'hFF, 1, 1'b0,
                 mk(0, 0, 1, 'h09, 'h04, 0,    0,    0, 0, 0, 7, 0, 0, 0, 0, 0)};
    vecs[23] = '{"ocw3_preinit", StbOcw3, 8'h0B, 1, 1'b0,
                 mk(0, 0, 1, 'h09, 'h04, 0,    0,    0, 0, 0, 7, 0, 0, 0, 0, 0)};
    vecs[24] = '{"icw1_reinit", StbIcw1, 8'h11, 1, 1'b0,
                 mk(0, 0, 0, 'h09, 'h04, 0,    0,    0, 0, 0, 7, 0, 0, 0, 0, 0)};
    vecs[25] = '{"icw2_to_icw3", StbIcw24, 8'h40, 1, 1'b1,
                 mk(0, 0, 0, 'h08, 'h04, 0,    0,    0, 0, 0, 7, 0, 0, 0, 0, 0)};

    // Reset state, both while held and after release
    repeat (3) @(negedge clk);
    expect_out('0, "reset_held");
    check_one();
    reset_n = 1'b1;
    expect_out('0, "reset_released");
    @(posedge clk); #1 check_one();
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Asynchronous reset while waiting for ICW3, checked before any clock edge
    #2 reset_n = 1'b0;
    #1;
    expect_out('0, "async_reset_in_icw3");
    check_one();
    expect_out('0, "reset_in_icw3_clocked");
    @(posedge clk); #1 check_one();
    @(negedge clk);
    reset_n = 1'b1;

    // OCW1 right after reset must not touch IMR
    post = '{"ocw1_after_reset", StbOcw1, 8'h5A, 1, 1'b1, '0};
    run_vec(post);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
